// File: rtl/tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tx_scheduler
//  Purpose  : Round-robin scheduler that hands one of NUM_REQ pending frame
//             descriptors at a time to an Ethernet framer, waits for the
//             framer's completion (with a timeout), then enforces an
//             inter-frame gap before the next grant.
//
//  Ports
//    clk            : single clock for all logic
//    rst_n          : asynchronous active-low reset
//    req            : bit i high = requester i has a frame pending
//    req_dest_addr  : per-requester destination MAC, requester i at [i*48 +: 48]
//    req_src_addr   : per-requester source MAC, same packing
//    req_eth_type   : per-requester EtherType, requester i at [i*16 +: 16]
//    req_data       : per-requester payload word, requester i at [i*32 +: 32]
//    grant          : one-hot owner of the framer, zero when idle
//    done           : one-cycle pulse on the bit of the requester whose frame
//                     completed
//    tx_start       : one-cycle start pulse to the framer
//    tx_dest_addr   : registered descriptor presented to the framer
//    tx_src_addr    :   "
//    tx_eth_type    :   "
//    tx_data        :   "
//    tx_done_in     : completion pulse from the framer
//    busy           : high whenever the scheduler is not idle
//    timeout_err    : one-cycle pulse when the framer failed to complete
//
//  Revision : 1.0  initial release
// ============================================================================
module tx_scheduler #(
   parameter int NUM_REQ        = 4,
   parameter int IFG_CYCLES     = 12,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*48-1:0] req_dest_addr,
   input  logic [NUM_REQ*48-1:0] req_src_addr,
   input  logic [NUM_REQ*16-1:0] req_eth_type,
   input  logic [NUM_REQ*32-1:0] req_data,
   output logic [NUM_REQ-1:0]    grant,
   output logic [NUM_REQ-1:0]    done,
   output logic                  tx_start,
   output logic [47:0]           tx_dest_addr,
   output logic [47:0]           tx_src_addr,
   output logic [15:0]           tx_eth_type,
   output logic [31:0]           tx_data,
   input  logic                  tx_done_in,
   output logic                  busy,
   output logic                  timeout_err
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

   localparam logic [IFG_W-1:0] IFG_LAST     = IFG_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
   localparam logic [15:0]      TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W:0]   NREQ_EXT     = (IDX_W + 1)'(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_RESET   = IDX_W'(NUM_REQ - 1);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_WAIT_DONE = 2'd1;
   localparam logic [1:0] S_IFG       = 2'd2;

   logic [1:0]         state;
   logic [1:0]         state_nxt;
   logic [IDX_W-1:0]   last_grant;
   logic [15:0]        wait_cnt;
   logic [IFG_W-1:0]   ifg_cnt;

   logic               sel_valid;
   logic [IDX_W-1:0]   sel_idx;
   logic [NUM_REQ-1:0] sel_onehot;
   logic [IDX_W:0]     cand_sum;
   logic [47:0]        sel_dest;
   logic [47:0]        sel_src;
   logic [15:0]        sel_type;
   logic [31:0]        sel_data;

   logic               grant_evt;
   logic               done_evt;
   logic               timeout_evt;

   // ------------------------------------------------------------------------
   // Round-robin pick: candidates last_grant+1 .. last_grant+NUM_REQ (mod
   // NUM_REQ). The loop walks from the farthest offset to the nearest so
   // the nearest pending requester is the one left in sel_idx.
   // ------------------------------------------------------------------------
   always_comb begin
      sel_valid  = 1'b0;
      sel_idx    = '0;
      sel_onehot = '0;
      cand_sum   = '0;
      for (int off = NUM_REQ; off >= 1; off--) begin
         cand_sum = {1'b0, last_grant} + (IDX_W + 1)'(off);
         if (cand_sum >= NREQ_EXT) begin
            cand_sum = cand_sum - NREQ_EXT;
         end
         if (req[cand_sum[IDX_W-1:0]]) begin
            sel_valid = 1'b1;
            sel_idx   = cand_sum[IDX_W-1:0];
         end
      end
      sel_onehot[sel_idx] = sel_valid;
   end

   // Descriptor of the selected requester.
   always_comb begin
      sel_dest = '0;
      sel_src  = '0;
      sel_type = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel_onehot[i]) begin
            sel_dest = req_dest_addr[i*48 +: 48];
            sel_src  = req_src_addr[i*48 +: 48];
            sel_type = req_eth_type[i*16 +: 16];
            sel_data = req_data[i*32 +: 32];
         end
      end
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: output / event decode
   // tx_start marks the first WAIT_DONE cycle, during which a completion
   // cannot belong to the new frame and is ignored.
   // wait_cnt is 0 in the tx_start cycle; the counter reaches TIMEOUT_CYCLES
   // at the edge that closes the cycle where it reads TIMEOUT_CYCLES-1. A
   // completion sampled at that same edge takes priority over the timeout.
   // ------------------------------------------------------------------------
   always_comb begin
      busy        = (state != S_IDLE);
      grant_evt   = (state == S_IDLE) && sel_valid;
      done_evt    = (state == S_WAIT_DONE) && !tx_start && tx_done_in;
      timeout_evt = (state == S_WAIT_DONE) && !done_evt && (wait_cnt == TIMEOUT_LAST);
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (grant_evt) begin
               state_nxt = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (done_evt || timeout_evt) begin
               state_nxt = (IFG_CYCLES > 0) ? S_IFG : S_IDLE;
            end
         end
         S_IFG: begin
            if (ifg_cnt == IFG_LAST) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Registered outputs, descriptor capture and counters
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant        <= '0;
         done         <= '0;
         tx_start     <= 1'b0;
         timeout_err  <= 1'b0;
         tx_dest_addr <= '0;
         tx_src_addr  <= '0;
         tx_eth_type  <= '0;
         tx_data      <= '0;
         last_grant   <= LAST_RESET;
         wait_cnt     <= '0;
         ifg_cnt      <= '0;
      end else begin
         tx_start    <= grant_evt;
         done        <= done_evt ? grant : '0;
         timeout_err <= timeout_evt;

         // Descriptor and grant are only written at the grant edge, so
         // requester activity during the frame cannot disturb them.
         if (grant_evt) begin
            grant        <= sel_onehot;
            last_grant   <= sel_idx;
            tx_dest_addr <= sel_dest;
            tx_src_addr  <= sel_src;
            tx_eth_type  <= sel_type;
            tx_data      <= sel_data;
         end else if (done_evt || timeout_evt) begin
            grant <= '0;
         end

         wait_cnt <= (state == S_WAIT_DONE) ? wait_cnt + 16'd1 : 16'd0;
         ifg_cnt  <= (state == S_IFG) ? ifg_cnt + 1'b1 : '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_scheduler
//  Purpose  : Self-checking bench for tx_scheduler (NUM_REQ=4, IFG=12,
//             TIMEOUT=64). A step table covers the single-request frame and
//             the round-robin rotation; hand-written sequences cover the
//             descriptor hold, timeout, completion/timeout boundary and
//             reset mid-frame.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tx_scheduler;

   localparam int N   = 4;
   localparam int IFG = 12;
   localparam int TMO = 64;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N*48-1:0] req_dest_addr;
   logic [N*48-1:0] req_src_addr;
   logic [N*16-1:0] req_eth_type;
   logic [N*32-1:0] req_data;
   logic [N-1:0]    grant;
   logic [N-1:0]    done;
   logic            tx_start;
   logic [47:0]     tx_dest_addr;
   logic [47:0]     tx_src_addr;
   logic [15:0]     tx_eth_type;
   logic [31:0]     tx_data;
   logic            tx_done_in;
   logic            busy;
   logic            timeout_err;

   always #5 clk = ~clk;

   tx_scheduler #(
      .NUM_REQ        (N),
      .IFG_CYCLES     (IFG),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req           (req),
      .req_dest_addr (req_dest_addr),
      .req_src_addr  (req_src_addr),
      .req_eth_type  (req_eth_type),
      .req_data      (req_data),
      .grant         (grant),
      .done          (done),
      .tx_start      (tx_start),
      .tx_dest_addr  (tx_dest_addr),
      .tx_src_addr   (tx_src_addr),
      .tx_eth_type   (tx_eth_type),
      .tx_data       (tx_data),
      .tx_done_in    (tx_done_in),
      .busy          (busy),
      .timeout_err   (timeout_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0] req;
      logic       din;
      int         cycles;
      logic [3:0] grant;
      logic       txs;
      logic [3:0] done;
      logic       busy;
      logic       tout;
      int         desc;
   } step_t;

   step_t steps[$];

   function automatic logic [47:0] dest_of(input int i);
      return {16'hDA00, 8'(i), 24'hA1B2C3};
   endfunction
   function automatic logic [47:0] src_of(input int i);
      return {16'h5A00, 8'(i), 24'h102030};
   endfunction
   function automatic logic [15:0] type_of(input int i);
      return {8'h88, 8'(i)};
   endfunction
   function automatic logic [31:0] data_of(input int i);
      return {8'hC0, 8'(i), 16'hBEEF};
   endfunction

   function automatic step_t mk(input logic [3:0] r, input logic di, input int cy,
                                input logic [3:0] g, input logic s, input logic [3:0] d,
                                input logic b, input logic t, input int ds);
      step_t st;
      st.req = r; st.din = di; st.cycles = cy; st.grant = g; st.txs = s;
      st.done = d; st.busy = b; st.tout = t; st.desc = ds;
      return st;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_outs(input string tag, input logic [3:0] g, input logic s,
                             input logic [3:0] d, input logic b, input logic t);
      check({tag, ".grant"},       64'(grant),       64'(g));
      check({tag, ".tx_start"},    64'(tx_start),    64'(s));
      check({tag, ".done"},        64'(done),        64'(d));
      check({tag, ".busy"},        64'(busy),        64'(b));
      check({tag, ".timeout_err"}, 64'(timeout_err), 64'(t));
   endtask

   task automatic check_desc(input string tag, input int i);
      check({tag, ".tx_dest"}, 64'(tx_dest_addr), 64'(dest_of(i)));
      check({tag, ".tx_src"},  64'(tx_src_addr),  64'(src_of(i)));
      check({tag, ".tx_type"}, 64'(tx_eth_type),  64'(type_of(i)));
      check({tag, ".tx_data"}, 64'(tx_data),      64'(data_of(i)));
   endtask

   // Invariants checked every cycle: at most one grant bit, no back-to-back tx_start.
   logic prev_txs = 1'b0;
   always @(negedge clk) begin
      check("grant_onehot0", 64'($onehot0(grant)), 64'd1);
      check("tx_start_b2b",  64'(prev_txs & tx_start), 64'd0);
      prev_txs <= tx_start;
   end

   initial begin
      logic [3:0] gr;
      int         order[4];

      rst_n      = 1'b0;
      req        = '0;
      tx_done_in = 1'b0;
      for (int i = 0; i < N; i++) begin
         req_dest_addr[i*48 +: 48] = dest_of(i);
         req_src_addr[i*48 +: 48]  = src_of(i);
         req_eth_type[i*16 +: 16]  = type_of(i);
         req_data[i*32 +: 32]      = data_of(i);
      end

      // Single request, done 20 cycles after tx_start, 12-cycle gap.
      steps.push_back(mk(4'b0001, 1'b0,  1, 4'b0001, 1'b1, 4'b0000, 1'b1, 1'b0,  0));
      steps.push_back(mk(4'b0001, 1'b0, 19, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0,  0));
      steps.push_back(mk(4'b0000, 1'b1,  1, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, -1));
      steps.push_back(mk(4'b0000, 1'b0, 11, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, -1));
      steps.push_back(mk(4'b0000, 1'b0,  1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, -1));
      // All four requesting: rotation 1, 2, 3, then back to 0.
      order = '{1, 2, 3, 0};
      for (int k = 0; k < 4; k++) begin
         gr = 4'(1 << order[k]);
         steps.push_back(mk(4'b1111, 1'b0,  1, gr,      1'b1, 4'b0000, 1'b1, 1'b0, order[k]));
         steps.push_back(mk(4'b1111, 1'b0,  1, gr,      1'b0, 4'b0000, 1'b1, 1'b0, order[k]));
         steps.push_back(mk(4'b1111, 1'b1,  1, 4'b0000, 1'b0, gr,      1'b1, 1'b0, -1));
         steps.push_back(mk(4'b1111, 1'b0, 11, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, -1));
         steps.push_back(mk(4'b1111, 1'b0,  1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, -1));
      end

      // Reset state.
      tick(2);
      check_outs("reset", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
      check("reset.tx_dest", 64'(tx_dest_addr), 64'd0);
      check("reset.tx_data", 64'(tx_data), 64'd0);
      rst_n = 1'b1;

      foreach (steps[k]) begin
         req        = steps[k].req;
         tx_done_in = steps[k].din;
         tick(steps[k].cycles);
         check_outs($sformatf("step%0d", k), steps[k].grant, steps[k].txs,
                    steps[k].done, steps[k].busy, steps[k].tout);
         if (steps[k].desc >= 0) begin
            check_desc($sformatf("step%0d", k), steps[k].desc);
         end
      end

      // Descriptor hold: requester 1's inputs change and its req drops mid-frame.
      req        = 4'b0010;
      tx_done_in = 1'b0;
      tick(1);
      check_outs("hold.grant", 4'b0010, 1'b1, 4'b0000, 1'b1, 1'b0);
      check_desc("hold.grant", 1);
      req_dest_addr[48 +: 48] = 48'hFFFF_FFFF_FFFF;
      req_data[32 +: 32]      = 32'h0;
      req                     = 4'b0000;
      tick(1);
      check_desc("hold.mid1", 1);
      tick(4);
      check_outs("hold.mid5", 4'b0010, 1'b0, 4'b0000, 1'b1, 1'b0);
      check_desc("hold.mid5", 1);
      tx_done_in = 1'b1;
      tick(1);
      check_outs("hold.done", 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b0);
      tx_done_in              = 1'b0;
      req_dest_addr[48 +: 48] = dest_of(1);
      req_data[32 +: 32]      = data_of(1);
      tick(12);
      check_outs("hold.idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

      // Timeout: framer never completes.
      req = 4'b0100;
      tick(1);
      check_outs("tmo.grant", 4'b0100, 1'b1, 4'b0000, 1'b1, 1'b0);
      tick(63);
      check_outs("tmo.cnt63", 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0);
      tick(1);
      check_outs("tmo.fire", 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1);
      tick(1);
      check_outs("tmo.after", 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
      tick(10);
      check_outs("tmo.ifg_end", 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
      tick(1);
      check_outs("tmo.idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
      tick(1);
      check_outs("tmo.regrant", 4'b0100, 1'b1, 4'b0000, 1'b1, 1'b0);

      // Completion during the tx_start cycle is ignored.
      tx_done_in = 1'b1;
      tick(1);
      check_outs("ign.start", 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0);
      // Completion sampled at the edge where the count reaches 64 wins.
      tx_done_in = 1'b0;
      tick(62);
      tx_done_in = 1'b1;
      tick(1);
      check_outs("bnd.done", 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b0);
      tx_done_in = 1'b0;
      req        = 4'b0000;
      tick(1);
      check_outs("bnd.after", 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
      tick(11);
      check_outs("bnd.idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

      // Reset in WAIT_DONE abandons the frame.
      req = 4'b0001;
      tick(1);
      check_outs("rst.grant", 4'b0001, 1'b1, 4'b0000, 1'b1, 1'b0);
      tick(3);
      rst_n = 1'b0;
      req   = 4'b0010;
      #1;
      check_outs("rst.async", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
      check("rst.tx_dest", 64'(tx_dest_addr), 64'd0);
      check("rst.tx_data", 64'(tx_data), 64'd0);
      tick(2);
      check_outs("rst.held", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick(1);
      check_outs("rst.first", 4'b0010, 1'b1, 4'b0000, 1'b1, 1'b0);
      check_desc("rst.first", 1);

      // After reset requester 0 has first priority.
      rst_n = 1'b0;
      req   = 4'b1001;
      tick(1);
      rst_n = 1'b1;
      tick(1);
      check_outs("rst.prio", 4'b0001, 1'b1, 4'b0000, 1'b1, 1'b0);
      check_desc("rst.prio", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
